// File: rtl/fpu_arb.sv
// Round-robin arbiter sharing one FPU between NUM_REQ requesters.
// One op in flight: grant, issue dval, wait for rdy or watchdog, respond.
module fpu_arb #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64,
  parameter int TMR_W   = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [4*NUM_REQ-1:0]   req_cmd,
  input  logic [32*NUM_REQ-1:0]  req_din1,
  input  logic [32*NUM_REQ-1:0]  req_din2,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [31:0]            rsp_data,
  output logic                   rsp_err,
  output logic [3:0]             fpu_cmd,
  output logic [31:0]            fpu_din1,
  output logic [31:0]            fpu_din2,
  output logic                   fpu_dval,
  input  logic [31:0]            fpu_result,
  input  logic                   fpu_rdy,
  output logic                   busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     gnt_q, gnt_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [31:0]       din1_q, din1_d;
  logic [31:0]       din2_q, din2_d;
  logic [31:0]       data_q, data_d;
  logic              err_q, err_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;

  logic              found;
  logic [IW-1:0]     pick;
  logic [IW-1:0]     idx;
  logic [3:0]        pick_cmd;
  logic [31:0]       pick_d1;
  logic [31:0]       pick_d2;
  logic              cmd_ok;

  // Scan from ptr upward with wrap; first valid wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = IW'((int'(ptr_q) + i) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    pick_cmd = req_cmd[4*pick +: 4];
    pick_d1  = req_din1[32*pick +: 32];
    pick_d2  = req_din2[32*pick +: 32];
    cmd_ok   = pick_cmd inside {4'b0001, 4'b0010, 4'b0011};
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    cmd_d     = cmd_q;
    din1_d    = din1_q;
    din2_d    = din2_q;
    data_d    = data_q;
    err_d     = err_q;
    tmr_d     = tmr_q;
    req_ready = '0;
    rsp_valid = '0;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          req_ready[pick] = 1'b1;
          gnt_d  = pick;
          cmd_d  = pick_cmd;
          din1_d = pick_d1;
          din2_d = pick_d2;
          if (cmd_ok) begin
            state_d = S_ISSUE;
          end else begin
            data_d  = '0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_ISSUE: begin
        tmr_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A completion in the final watchdog cycle still counts.
        if (fpu_rdy) begin
          data_d  = fpu_result;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
          data_d  = QNAN;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_RESP: begin
        rsp_valid[gnt_q] = 1'b1;
        if (rsp_ready[gnt_q]) begin
          state_d = S_IDLE;
          ptr_d   = (gnt_q == IW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      cmd_q   <= '0;
      din1_q  <= '0;
      din2_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cmd_q   <= cmd_d;
      din1_q  <= din1_d;
      din2_q  <= din2_d;
      data_q  <= data_d;
      err_q   <= err_d;
      tmr_q   <= tmr_d;
    end
  end

  assign fpu_cmd  = cmd_q;
  assign fpu_din1 = din1_q;
  assign fpu_din2 = din2_q;
  assign fpu_dval = (state_q == S_ISSUE);
  assign busy     = (state_q != S_IDLE);
  assign rsp_data = data_q;
  assign rsp_err  = err_q;

endmodule
